// File: rtl/biriscv_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : biriscv_mul_arbiter
// Purpose  : Shares a single iterative multiplier between the two issue pipes
//            of the dual-issue core. Holds one active op and one pending op.
//            It launches them one after another and returns each result tagged
//            with its pipe and destination register. On a flush, an op that is
//            already inside the multiplier is drained and its result is
//            dropped.
// Options  : BIRISCV_MUL_ARB_WATCHDOG_EN - when defined, enables a sticky
//            watchdog on error_o after WATCHDOG_CYCLES cycles in WAIT/DRAIN.
//            When undefined, error_o is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module biriscv_mul_arbiter #(
  parameter int WATCHDOG_CYCLES = 15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [31:0] req0_ra_i,
  input  logic [31:0] req0_rb_i,
  input  logic [4:0]  req0_rd_idx_i,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [31:0] req1_ra_i,
  input  logic [31:0] req1_rb_i,
  input  logic [4:0]  req1_rd_idx_i,
  input  logic        flush_i,
  output logic        mul_valid_o,
  output logic [31:0] mul_ra_o,
  output logic [31:0] mul_rb_o,
  input  logic        mul_wb_valid_i,
  input  logic [31:0] mul_wb_value_i,
  output logic        wb_valid_o,
  output logic        wb_pipe_o,
  output logic [4:0]  wb_rd_idx_o,
  output logic [31:0] wb_value_o,
  output logic        busy_o,
  output logic        error_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t      state_q, state_d;

  // Active slot: the op being launched or already inside the multiplier
  logic        act_pipe_q, act_pipe_d;
  logic [4:0]  act_rd_q,   act_rd_d;
  logic [31:0] act_ra_q,   act_ra_d;
  logic [31:0] act_rb_q,   act_rb_d;

  // Pending slot: only filled by a dual accept, so it always holds a pipe 1 op
  logic        pend_valid_q, pend_valid_d;
  logic [4:0]  pend_rd_q,    pend_rd_d;
  logic [31:0] pend_ra_q,    pend_ra_d;
  logic [31:0] pend_rb_q,    pend_rb_d;

  logic        mul_valid_q, mul_valid_d;
  logic        busy_q,      busy_d;
  logic        w_wb_valid;
  logic        w_accept_ok;

  // Requests are taken only in IDLE, and never in a flush cycle
  assign w_accept_ok  = (state_q == ST_IDLE) && !flush_i;
  assign req0_ready_o = w_accept_ok;
  assign req1_ready_o = w_accept_ok;

  // Next-state logic, slot updates and the combinational writeback strobe
  always_comb begin
    state_d      = state_q;
    act_pipe_d   = act_pipe_q;
    act_rd_d     = act_rd_q;
    act_ra_d     = act_ra_q;
    act_rb_d     = act_rb_q;
    pend_valid_d = pend_valid_q;
    pend_rd_d    = pend_rd_q;
    pend_ra_d    = pend_ra_q;
    pend_rb_d    = pend_rb_q;
    w_wb_valid   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!flush_i) begin
          if (req0_valid_i) begin
            // Pipe 0 holds the older instruction, so it goes first
            act_pipe_d = 1'b0;
            act_rd_d   = req0_rd_idx_i;
            act_ra_d   = req0_ra_i;
            act_rb_d   = req0_rb_i;
            state_d    = ST_ISSUE;
            if (req1_valid_i) begin
              pend_valid_d = 1'b1;
              pend_rd_d    = req1_rd_idx_i;
              pend_ra_d    = req1_ra_i;
              pend_rb_d    = req1_rb_i;
            end
          end else if (req1_valid_i) begin
            act_pipe_d = 1'b1;
            act_rd_d   = req1_rd_idx_i;
            act_ra_d   = req1_ra_i;
            act_rb_d   = req1_rb_i;
            state_d    = ST_ISSUE;
          end
        end
      end

      ST_ISSUE: begin
        // The launch strobe fires this cycle no matter what; a flush only
        // means the result will be thrown away later
        if (flush_i) begin
          pend_valid_d = 1'b0;
          state_d      = ST_DRAIN;
        end else begin
          state_d      = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (mul_wb_valid_i) begin
          if (flush_i) begin
            pend_valid_d = 1'b0;
            state_d      = ST_IDLE;
          end else begin
            w_wb_valid = 1'b1;
            if (pend_valid_q) begin
              // The multiplier is idle again from the next cycle, so the
              // pending op can launch right away
              act_pipe_d   = 1'b1;
              act_rd_d     = pend_rd_q;
              act_ra_d     = pend_ra_q;
              act_rb_d     = pend_rb_q;
              pend_valid_d = 1'b0;
              state_d      = ST_ISSUE;
            end else begin
              state_d      = ST_IDLE;
            end
          end
        end else if (flush_i) begin
          pend_valid_d = 1'b0;
          state_d      = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        // Flushed op still inside the multiplier: swallow its result
        if (mul_wb_valid_i) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    mul_valid_d = (state_d == ST_ISSUE);
    busy_d      = (state_d != ST_IDLE) || pend_valid_d;
  end

  // State, slot and registered-output flops
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      act_pipe_q   <= 1'b0;
      act_rd_q     <= 5'd0;
      act_ra_q     <= 32'd0;
      act_rb_q     <= 32'd0;
      pend_valid_q <= 1'b0;
      pend_rd_q    <= 5'd0;
      pend_ra_q    <= 32'd0;
      pend_rb_q    <= 32'd0;
      mul_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      act_pipe_q   <= act_pipe_d;
      act_rd_q     <= act_rd_d;
      act_ra_q     <= act_ra_d;
      act_rb_q     <= act_rb_d;
      pend_valid_q <= pend_valid_d;
      pend_rd_q    <= pend_rd_d;
      pend_ra_q    <= pend_ra_d;
      pend_rb_q    <= pend_rb_d;
      mul_valid_q  <= mul_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign mul_valid_o = mul_valid_q;
  assign mul_ra_o    = act_ra_q;
  assign mul_rb_o    = act_rb_q;
  assign wb_valid_o  = w_wb_valid;
  assign wb_pipe_o   = act_pipe_q;
  assign wb_rd_idx_o = act_rd_q;
  assign wb_value_o  = w_wb_valid ? mul_wb_value_i : 32'd0;
  assign busy_o      = busy_q;

`ifdef BIRISCV_MUL_ARB_WATCHDOG_EN
  localparam int C_WD_W = $clog2(WATCHDOG_CYCLES + 1);
  localparam logic [C_WD_W-1:0] C_WD_LIMIT = C_WD_W'(WATCHDOG_CYCLES);

  logic [C_WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic              error_q,  error_d;

  // Count cycles spent waiting on the multiplier; saturate at the limit
  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (state_d == ST_ISSUE) begin
      wd_cnt_d = '0;
    end else if (((state_q == ST_WAIT) || (state_q == ST_DRAIN)) &&
                 (wd_cnt_q != C_WD_LIMIT)) begin
      wd_cnt_d = wd_cnt_q + C_WD_W'(1);
    end
    error_d = error_q || (wd_cnt_d == C_WD_LIMIT);
  end

  // Watchdog counter and sticky error flag
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wd_cnt_q <= '0;
      error_q  <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      error_q  <= error_d;
    end
  end

  assign error_o = error_q;
`else
  logic w_unused_wd;
  assign w_unused_wd = (WATCHDOG_CYCLES != 0);
  assign error_o     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_biriscv_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_biriscv_mul_arbiter
// Purpose  : Directed bench for biriscv_mul_arbiter. It runs a queue-based
//            behavioural model that is checked every cycle. Hand-computed
//            literal checks pin the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_biriscv_mul_arbiter;

  localparam int WD = 15;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req0_valid_i, req1_valid_i, flush_i, mul_wb_valid_i;
  logic        req0_ready_o, req1_ready_o;
  logic [31:0] req0_ra_i, req0_rb_i, req1_ra_i, req1_rb_i, mul_wb_value_i;
  logic [4:0]  req0_rd_idx_i, req1_rd_idx_i;
  logic        mul_valid_o, wb_valid_o, wb_pipe_o, busy_o, error_o;
  logic [31:0] mul_ra_o, mul_rb_o, wb_value_o;
  logic [4:0]  wb_rd_idx_o;

  int n_tests = 0;
  int n_fail  = 0;

  biriscv_mul_arbiter #(.WATCHDOG_CYCLES(WD)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
    .req0_ra_i(req0_ra_i), .req0_rb_i(req0_rb_i), .req0_rd_idx_i(req0_rd_idx_i),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
    .req1_ra_i(req1_ra_i), .req1_rb_i(req1_rb_i), .req1_rd_idx_i(req1_rd_idx_i),
    .flush_i(flush_i),
    .mul_valid_o(mul_valid_o), .mul_ra_o(mul_ra_o), .mul_rb_o(mul_rb_o),
    .mul_wb_valid_i(mul_wb_valid_i), .mul_wb_value_i(mul_wb_value_i),
    .wb_valid_o(wb_valid_o), .wb_pipe_o(wb_pipe_o), .wb_rd_idx_o(wb_rd_idx_o),
    .wb_value_o(wb_value_o), .busy_o(busy_o), .error_o(error_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  typedef struct packed {
    logic        pipe;
    logic [4:0]  rd;
    logic [31:0] ra;
    logic [31:0] rb;
  } op_t;

  op_t ops[$];        // accepted ops not yet retired or flushed
  bit  m_launch;      // a launch strobe is due this cycle
  bit  m_busy;        // the multiplier is computing something
  bit  m_discard;     // whatever it is computing was flushed
  int  m_wd;
  bit  m_err;

  initial begin
    bit  e_idle, e_ready, e_wb;
    op_t tmp;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        ops.delete();
        m_launch = 0; m_busy = 0; m_discard = 0; m_wd = 0; m_err = 0;
        chk("m_rst_mul_valid", mul_valid_o, 0);
        chk("m_rst_busy", busy_o, 0);
        chk("m_rst_wb_valid", wb_valid_o, 0);
        chk("m_rst_error", error_o, 0);
      end else begin
        e_idle  = !m_launch && !m_busy;
        e_ready = e_idle && !flush_i;
        e_wb    = m_busy && !m_discard && mul_wb_valid_i && !flush_i;
        chk("m_ready0", req0_ready_o, e_ready);
        chk("m_ready1", req1_ready_o, e_ready);
        chk("m_mul_valid", mul_valid_o, m_launch);
        chk("m_busy", busy_o, !e_idle);
        chk("m_wb_valid", wb_valid_o, e_wb);
        chk("m_error", error_o, m_err);
        if (m_launch && ops.size() != 0) begin
          chk("m_mul_ra", mul_ra_o, ops[0].ra);
          chk("m_mul_rb", mul_rb_o, ops[0].rb);
        end
        if (e_wb && ops.size() != 0) begin
          chk("m_wb_pipe", wb_pipe_o, ops[0].pipe);
          chk("m_wb_rd", wb_rd_idx_o, ops[0].rd);
          chk("m_wb_value", wb_value_o, mul_wb_value_i);
        end
        // advance the model to the next cycle
        if (e_idle) begin
          if (!flush_i) begin
            if (req0_valid_i) begin
              tmp = '{pipe: 1'b0, rd: req0_rd_idx_i, ra: req0_ra_i, rb: req0_rb_i};
              ops.push_back(tmp);
            end
            if (req1_valid_i) begin
              tmp = '{pipe: 1'b1, rd: req1_rd_idx_i, ra: req1_ra_i, rb: req1_rb_i};
              ops.push_back(tmp);
            end
            m_launch = (ops.size() != 0);
          end
        end else if (m_launch) begin
          m_launch = 0;
          m_busy   = 1;
          m_wd     = 0;
          if (flush_i) begin
            ops.delete();
            m_discard = 1;
          end
        end else begin
          m_wd++;
`ifdef BIRISCV_MUL_ARB_WATCHDOG_EN
          if (m_wd >= WD) m_err = 1;
`endif
          if (mul_wb_valid_i) begin
            m_busy = 0;
            if (m_discard) begin
              m_discard = 0;
            end else if (flush_i) begin
              ops.delete();
            end else begin
              void'(ops.pop_front());
              m_launch = (ops.size() != 0);
            end
          end else if (flush_i && !m_discard) begin
            ops.delete();
            m_discard = 1;
          end
        end
      end
    end
  end

  // ------------------------------------------------------------- stimulus
  task automatic idle_in();
    req0_valid_i = 0; req1_valid_i = 0; flush_i = 0;
    mul_wb_valid_i = 0; mul_wb_value_i = 0;
  endtask

  task automatic nxt();
    @(posedge clk_i);
    #1;
  endtask

  task automatic neg();
    @(negedge clk_i);
  endtask

  task automatic set0(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    req0_valid_i = 1; req0_ra_i = a; req0_rb_i = b; req0_rd_idx_i = rd;
  endtask

  task automatic set1(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    req1_valid_i = 1; req1_ra_i = a; req1_rb_i = b; req1_rd_idx_i = rd;
  endtask

  initial begin
    idle_in();
    req0_ra_i = 0; req0_rb_i = 0; req0_rd_idx_i = 0;
    req1_ra_i = 0; req1_rb_i = 0; req1_rd_idx_i = 0;
    rst_i = 1;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 0;
    neg();
    chk("rst_busy", busy_o, 0);
    chk("rst_mul_valid", mul_valid_o, 0);
    chk("rst_ready0", req0_ready_o, 1);
    nxt();

    // single op 3*7 from pipe 0
    set0(3, 7, 5);
    neg(); chk("t1_ready", req0_ready_o, 1);
    nxt(); idle_in();
    neg(); chk("t1_launch", mul_valid_o, 1); chk("t1_ra", mul_ra_o, 3); chk("t1_rb", mul_rb_o, 7);
    nxt(); neg(); chk("t1_one_pulse", mul_valid_o, 0);
    nxt(); nxt(); mul_wb_valid_i = 1; mul_wb_value_i = 21;
    neg(); chk("t1_wb_valid", wb_valid_o, 1); chk("t1_wb_pipe", wb_pipe_o, 0);
    chk("t1_wb_rd", wb_rd_idx_o, 5); chk("t1_wb_value", wb_value_o, 21);
    nxt(); idle_in();
    neg(); chk("t1_ready_after", req0_ready_o, 1); chk("t1_busy_after", busy_o, 0);
    nxt();

    // dual accept, program order
    set0(2, 5, 1); set1(32'h10000, 32'h10000, 2);
    neg(); chk("t2_ready0", req0_ready_o, 1); chk("t2_ready1", req1_ready_o, 1);
    nxt(); idle_in();
    neg(); chk("t2_launch0", mul_valid_o, 1); chk("t2_ra0", mul_ra_o, 2);
    nxt(); nxt(); mul_wb_valid_i = 1; mul_wb_value_i = 10;
    neg(); chk("t2_wb0_pipe", wb_pipe_o, 0); chk("t2_wb0_rd", wb_rd_idx_o, 1);
    chk("t2_wb0_value", wb_value_o, 10);
    nxt(); idle_in();
    neg(); chk("t2_launch1", mul_valid_o, 1); chk("t2_ra1", mul_ra_o, 32'h10000);
    chk("t2_rb1", mul_rb_o, 32'h10000); chk("t2_busy", busy_o, 1);
    nxt(); nxt(); mul_wb_valid_i = 1; mul_wb_value_i = 32'h0;
    neg(); chk("t2_wb1_valid", wb_valid_o, 1); chk("t2_wb1_pipe", wb_pipe_o, 1);
    chk("t2_wb1_rd", wb_rd_idx_o, 2); chk("t2_wb1_value", wb_value_o, 0);
    nxt(); idle_in();
    neg(); chk("t2_busy_end", busy_o, 0);
    nxt();

    // flush in WAIT with pending occupied
    set0(4, 4, 3); set1(6, 6, 4);
    nxt(); idle_in();
    nxt(); flush_i = 1;
    neg(); chk("t3_no_wb", wb_valid_o, 0); chk("t3_ready_flush", req0_ready_o, 0);
    nxt(); flush_i = 0;
    neg(); chk("t3_drain_busy", busy_o, 1);
    nxt(); mul_wb_valid_i = 1; mul_wb_value_i = 16;
    neg(); chk("t3_drain_wb", wb_valid_o, 0);
    nxt(); idle_in();
    neg(); chk("t3_busy_drop", busy_o, 0); chk("t3_no_launch", mul_valid_o, 0);
    nxt();
    neg(); chk("t3_no_launch2", mul_valid_o, 0);
    nxt();

    // flush coincident with result, then flush with requests in IDLE
    set0(5, 5, 6);
    nxt(); idle_in();
    nxt(); mul_wb_valid_i = 1; mul_wb_value_i = 25; flush_i = 1;
    neg(); chk("t4_suppressed", wb_valid_o, 0);
    nxt(); idle_in();
    neg(); chk("t4_idle_ready", req0_ready_o, 1); chk("t4_idle_busy", busy_o, 0);
    set0(1, 2, 7); set1(3, 4, 8); flush_i = 1;
    neg(); chk("t4_flush_ready0", req0_ready_o, 0); chk("t4_flush_ready1", req1_ready_o, 0);
    nxt(); idle_in();
    neg(); chk("t4_no_accept", mul_valid_o, 0); chk("t4_no_busy", busy_o, 0);
    nxt();

    // reset while in WAIT, then a stale result
    set1(9, 4, 17);
    nxt(); idle_in();
    nxt();
    neg(); chk("t5_act_pipe", wb_pipe_o, 1); chk("t5_act_rd", wb_rd_idx_o, 17);
    nxt(); rst_i = 1;
    #1;
    chk("t5_rst_mul_valid", mul_valid_o, 0); chk("t5_rst_ra", mul_ra_o, 0);
    chk("t5_rst_rb", mul_rb_o, 0); chk("t5_rst_pipe", wb_pipe_o, 0);
    chk("t5_rst_rd", wb_rd_idx_o, 0); chk("t5_rst_busy", busy_o, 0);
    chk("t5_rst_error", error_o, 0); chk("t5_rst_wb", wb_valid_o, 0);
    nxt(); rst_i = 0; mul_wb_valid_i = 1; mul_wb_value_i = 36;
    neg(); chk("t5_stale_wb", wb_valid_o, 0); chk("t5_stale_ready", req0_ready_o, 1);
    nxt(); idle_in();
    neg(); chk("t5_no_launch", mul_valid_o, 0);
    nxt();

    // long wait (watchdog), then back-to-back accept after the IDLE return
    set0(1, 1, 7);
    nxt(); idle_in();
    repeat (20) nxt();
    neg();
`ifdef BIRISCV_MUL_ARB_WATCHDOG_EN
    chk("t6_error", error_o, 1);
`else
    chk("t6_error", error_o, 0);
`endif
    nxt(); mul_wb_valid_i = 1; mul_wb_value_i = 1;
    neg(); chk("t6_wb_valid", wb_valid_o, 1); chk("t6_wb_rd", wb_rd_idx_o, 7);
    nxt(); idle_in(); set0(8, 8, 9);
    neg(); chk("t6_b2b_ready", req0_ready_o, 1);
    nxt(); idle_in();
    neg(); chk("t6_b2b_launch", mul_valid_o, 1); chk("t6_b2b_ra", mul_ra_o, 8);
    nxt(); nxt(); mul_wb_valid_i = 1; mul_wb_value_i = 64;
    neg(); chk("t6_b2b_wb", wb_value_o, 64); chk("t6_b2b_pipe", wb_pipe_o, 0);
    nxt(); idle_in();
    neg();
`ifdef BIRISCV_MUL_ARB_WATCHDOG_EN
    chk("t6_error_sticky", error_o, 1);
`else
    chk("t6_error_sticky", error_o, 0);
`endif
    nxt();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
